// File: rtl/pipe_hazard_arbiter.sv
// ---------------------------------------------------------------------------
// pipe_hazard_arbiter
//
// Hazard and stall arbiter for the 5-stage core with split I/D caches.
// - Selects the forwarding source for both ID operands. EX has priority over
//   MEM, and MEM has priority over WB.
// - Inserts LU_BUBBLES front-end bubbles when a load in EX feeds the
//   instruction in ID.
// - Sequences I-miss, D-miss and overlapping (BOTH) miss stalls. Fill-complete
//   pulses that arrive during BOTH are latched, so they can come in any order.
// - Holds the front end on HLT.
// - Gates mispredict flush and BTB write on front-end advance.
//
// Optional build macro: PERF_CNT_EN
//   defined   : stall_cnt / miss_cnt are saturating performance counters
//   undefined : stall_cnt / miss_cnt are tied to 0 and no counter flops exist
//
// Ports
//   clk, reset_n                    clock, async active-low reset
//   id_rs, id_rt, id_use_rs/rt      ID source operands and their use flags
//   id_halt                         HLT in ID
//   ex_is_load                      load in EX
//   dest_ex/m/wb, rw_ex/m/wb        per-stage destination and RegWrite
//   i_hit, d_hit                    cache hits (d_hit=1 when no D access)
//   i_ready, d_ready                single-cycle fill-complete pulses
//   redirect, btb_upd               mispredict / BTB write request from ID
//   pc_we .. wb_we                  stage latch enables
//   bubble_ex                       inject NOP into ID/EX
//   flush_id, btb_we                gated squash / BTB write
//   fwd_a, fwd_b                    0 RF, 1 EX, 2 MEM, 3 WB
//   both_access                     both caches missing concurrently
//   stall_cnt, miss_cnt             performance counters
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | normal flow; hazards and misses are detected here
// S_I_MISS   | instruction fill pending; front end held, back end drains
// S_D_MISS   | data fill pending; whole pipe frozen
// S_BOTH     | both fills pending; ready pulses latched until both arrive
// S_LU_STALL | load-use bubbles being inserted
// ---------------------------------------------------------------------------
module pipe_hazard_arbiter #(
  parameter int REG_AW     = 2,
  parameter int LU_BUBBLES = 1,   // legal range 1..3
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_halt,
  input  logic              ex_is_load,
  input  logic [REG_AW-1:0] dest_ex,
  input  logic [REG_AW-1:0] dest_m,
  input  logic [REG_AW-1:0] dest_wb,
  input  logic              rw_ex,
  input  logic              rw_m,
  input  logic              rw_wb,
  input  logic              i_hit,
  input  logic              d_hit,
  input  logic              i_ready,
  input  logic              d_ready,
  input  logic              redirect,
  input  logic              btb_upd,
  output logic              pc_we,
  output logic              id_we,
  output logic              ex_we,
  output logic              m_we,
  output logic              wb_we,
  output logic              bubble_ex,
  output logic              flush_id,
  output logic              btb_we,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              both_access,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_I_MISS   = 3'd1,
    S_D_MISS   = 3'd2,
    S_BOTH     = 3'd3,
    S_LU_STALL = 3'd4
  } state_t;

  // The counter holds the number of bubbles still to come after the current one.
  localparam logic [1:0] LU_INIT = 2'(LU_BUBBLES - 1);

  state_t     state, state_nx;
  logic [1:0] lu_cnt, lu_cnt_nx;
  logic       i_done, i_done_nx;
  logic       d_done, d_done_nx;

  logic       ex_rs_hit, ex_rt_hit;
  logic       lu;
  logic       stall_all;   // freeze every stage
  logic       stall_fe;    // hold PC/IF-ID, bubble into EX, back end drains
  logic       both_c;

  // ---------------- forwarding ----------------
  assign ex_rs_hit = id_use_rs && rw_ex && (id_rs == dest_ex);
  assign ex_rt_hit = id_use_rt && rw_ex && (id_rt == dest_ex);
  assign lu        = ex_is_load && (ex_rs_hit || ex_rt_hit);

  always_comb begin
    fwd_a = 2'd0;
    if (ex_rs_hit)
      fwd_a = 2'd1;
    else if (id_use_rs && rw_m && (id_rs == dest_m))
      fwd_a = 2'd2;
    else if (id_use_rs && rw_wb && (id_rs == dest_wb))
      fwd_a = 2'd3;
  end

  always_comb begin
    fwd_b = 2'd0;
    if (ex_rt_hit)
      fwd_b = 2'd1;
    else if (id_use_rt && rw_m && (id_rt == dest_m))
      fwd_b = 2'd2;
    else if (id_use_rt && rw_wb && (id_rt == dest_wb))
      fwd_b = 2'd3;
  end

  // ---------------- FSM next state ----------------
  always_comb begin
    state_nx  = state;
    lu_cnt_nx = lu_cnt;
    i_done_nx = i_done;
    d_done_nx = d_done;
    stall_all = 1'b0;
    stall_fe  = 1'b0;
    both_c    = 1'b0;
    case (state)
      S_IDLE: begin
        if (!d_hit) begin
          state_nx  = S_D_MISS;
          stall_all = 1'b1;
        end else if (!i_hit) begin
          state_nx = S_I_MISS;
          stall_fe = 1'b1;
        end else if (id_halt) begin
          // HLT holds the front end and leaves the state alone, so a pending
          // load-use is re-evaluated once the halt drops.
          stall_fe = 1'b1;
        end else if (lu) begin
          state_nx  = S_LU_STALL;
          stall_fe  = 1'b1;
          lu_cnt_nx = LU_INIT;
        end
      end
      S_I_MISS: begin
        if (!d_hit) begin
          state_nx  = S_BOTH;
          stall_all = 1'b1;
          both_c    = 1'b1;
          if (i_ready)
            i_done_nx = 1'b1;
        end else if (!i_ready) begin
          stall_fe = 1'b1;
        end else begin
          state_nx = S_IDLE;
        end
      end
      S_D_MISS: begin
        if (!i_hit) begin
          state_nx  = S_BOTH;
          stall_all = 1'b1;
          both_c    = 1'b1;
          if (d_ready)
            d_done_nx = 1'b1;
        end else if (!d_ready) begin
          stall_all = 1'b1;
        end else begin
          state_nx = S_IDLE;
        end
      end
      S_BOTH: begin
        both_c = 1'b1;
        if ((i_done || i_ready) && (d_done || d_ready)) begin
          state_nx  = S_IDLE;
          i_done_nx = 1'b0;
          d_done_nx = 1'b0;
        end else begin
          stall_all = 1'b1;
          if (i_ready)
            i_done_nx = 1'b1;
          if (d_ready)
            d_done_nx = 1'b1;
        end
      end
      S_LU_STALL: begin
        if (!d_hit) begin
          state_nx  = S_D_MISS;
          stall_all = 1'b1;
        end else if (id_halt && i_hit) begin
          // The remaining bubble count is frozen while halted.
          stall_fe = 1'b1;
        end else if (lu_cnt == 2'd0) begin
          state_nx = S_IDLE;
        end else begin
          lu_cnt_nx = lu_cnt - 2'd1;
          stall_fe  = 1'b1;
        end
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      lu_cnt <= 2'd0;
      i_done <= 1'b0;
      d_done <= 1'b0;
    end else begin
      state  <= state_nx;
      lu_cnt <= lu_cnt_nx;
      i_done <= i_done_nx;
      d_done <= d_done_nx;
    end
  end

  // ---------------- enables and gated side effects ----------------
  // The outputs are combinational. They are forced to their reset values
  // while reset_n is low, whatever the inputs are doing.
  always_comb begin
    pc_we       = 1'b1;
    id_we       = 1'b1;
    ex_we       = 1'b1;
    m_we        = 1'b1;
    wb_we       = 1'b1;
    bubble_ex   = 1'b0;
    both_access = 1'b0;
    flush_id    = 1'b0;
    btb_we      = 1'b0;
    if (reset_n) begin
      pc_we       = !(stall_all || stall_fe);
      id_we       = !(stall_all || stall_fe);
      ex_we       = !stall_all;
      m_we        = !stall_all;
      wb_we       = !stall_all;
      bubble_ex   = stall_fe;
      both_access = both_c;
      // A redirect or BTB write only takes effect in a cycle where the front
      // end actually moves.
      flush_id    = redirect && pc_we;
      btb_we      = btb_upd && pc_we;
    end
  end

  // ---------------- performance counters ----------------
`ifdef PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] stall_q, miss_q;
  logic             miss_evt;

  assign miss_evt = ((state == S_IDLE) &&
                     ((state_nx == S_I_MISS) || (state_nx == S_D_MISS))) ||
                    (((state == S_I_MISS) || (state == S_D_MISS)) &&
                     (state_nx == S_BOTH));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_q <= '0;
      miss_q  <= '0;
    end else begin
      if (!pc_we && (stall_q != '1))
        stall_q <= stall_q + CNT_ONE;
      if (miss_evt && (miss_q != '1))
        miss_q <= miss_q + CNT_ONE;
    end
  end

  assign stall_cnt = stall_q;
  assign miss_cnt  = miss_q;
`else
  assign stall_cnt = '0;
  assign miss_cnt  = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_arbiter.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_arbiter
//
// Self-checking bench for pipe_hazard_arbiter. It uses two instances: u_dut
// with LU_BUBBLES=2 and u_dut1 with LU_BUBBLES=1. Both instances receive the
// same inputs.
//
// In every cycle the bench pushes the expected output vector to a queue when
// it drives the stimulus. It then pops that vector and compares it at the
// falling edge.
//
// Layout of the output vector:
//   {pc_we, id_we, ex_we, m_we, wb_we, bubble_ex, flush_id, btb_we,
//    both_access, fwd_a, fwd_b}
// ---------------------------------------------------------------------------
module tb_pipe_hazard_arbiter;

  localparam int REG_AW = 2;
  localparam int CNT_W  = 16;

  localparam logic [1:0] M_ADV  = 2'd0;
  localparam logic [1:0] M_FE0  = 2'd1;
  localparam logic [1:0] M_ALL0 = 2'd2;

`ifdef PERF_CNT_EN
  localparam int PERF = 1;
`else
  localparam int PERF = 0;
`endif

  logic              clk = 1'b0;
  logic              reset_n;
  logic [REG_AW-1:0] id_rs, id_rt, dest_ex, dest_m, dest_wb;
  logic              id_use_rs, id_use_rt, id_halt, ex_is_load;
  logic              rw_ex, rw_m, rw_wb, i_hit, d_hit, i_ready, d_ready;
  logic              redirect, btb_upd;

  logic              pc_we, id_we, ex_we, m_we, wb_we, bubble_ex, flush_id, btb_we, both_access;
  logic [1:0]        fwd_a, fwd_b;
  logic [CNT_W-1:0]  stall_cnt, miss_cnt;

  logic              pc_we1, id_we1, ex_we1, m_we1, wb_we1, bubble_ex1, flush_id1, btb_we1, both_access1;
  logic [1:0]        fwd_a1, fwd_b1;
  logic [CNT_W-1:0]  stall_cnt1, miss_cnt1;

  logic [12:0]       obs, obs1;
  logic [12:0]       sb[$];
  logic [12:0]       sb1[$];
  int                n_cmp = 0;
  int                n_err = 0;

  assign obs  = {pc_we, id_we, ex_we, m_we, wb_we, bubble_ex, flush_id, btb_we,
                 both_access, fwd_a, fwd_b};
  assign obs1 = {pc_we1, id_we1, ex_we1, m_we1, wb_we1, bubble_ex1, flush_id1, btb_we1,
                 both_access1, fwd_a1, fwd_b1};

  always #5 clk = ~clk;

  pipe_hazard_arbiter #(.REG_AW(REG_AW), .LU_BUBBLES(2), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_halt(id_halt), .ex_is_load(ex_is_load),
    .dest_ex(dest_ex), .dest_m(dest_m), .dest_wb(dest_wb),
    .rw_ex(rw_ex), .rw_m(rw_m), .rw_wb(rw_wb),
    .i_hit(i_hit), .d_hit(d_hit), .i_ready(i_ready), .d_ready(d_ready),
    .redirect(redirect), .btb_upd(btb_upd),
    .pc_we(pc_we), .id_we(id_we), .ex_we(ex_we), .m_we(m_we), .wb_we(wb_we),
    .bubble_ex(bubble_ex), .flush_id(flush_id), .btb_we(btb_we),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .both_access(both_access),
    .stall_cnt(stall_cnt), .miss_cnt(miss_cnt)
  );

  pipe_hazard_arbiter #(.REG_AW(REG_AW), .LU_BUBBLES(1), .CNT_W(CNT_W)) u_dut1 (
    .clk(clk), .reset_n(reset_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_halt(id_halt), .ex_is_load(ex_is_load),
    .dest_ex(dest_ex), .dest_m(dest_m), .dest_wb(dest_wb),
    .rw_ex(rw_ex), .rw_m(rw_m), .rw_wb(rw_wb),
    .i_hit(i_hit), .d_hit(d_hit), .i_ready(i_ready), .d_ready(d_ready),
    .redirect(redirect), .btb_upd(btb_upd),
    .pc_we(pc_we1), .id_we(id_we1), .ex_we(ex_we1), .m_we(m_we1), .wb_we(wb_we1),
    .bubble_ex(bubble_ex1), .flush_id(flush_id1), .btb_we(btb_we1),
    .fwd_a(fwd_a1), .fwd_b(fwd_b1), .both_access(both_access1),
    .stall_cnt(stall_cnt1), .miss_cnt(miss_cnt1)
  );

  function automatic logic [12:0] exp_o(input logic [1:0] m, input logic fl, input logic bt,
                                        input logic ba, input logic [1:0] fa, input logic [1:0] fb);
    logic [4:0] we;
    logic       bub;
    case (m)
      M_ADV:   begin we = 5'b11111; bub = 1'b0; end
      M_FE0:   begin we = 5'b00111; bub = 1'b1; end
      default: begin we = 5'b00000; bub = 1'b0; end
    endcase
    return {we, bub, fl, bt, ba, fa, fb};
  endfunction

  task automatic idle_inputs();
    id_rs = '0; id_rt = '0; id_use_rs = 1'b0; id_use_rt = 1'b0; id_halt = 1'b0;
    ex_is_load = 1'b0; dest_ex = '0; dest_m = '0; dest_wb = '0;
    rw_ex = 1'b0; rw_m = 1'b0; rw_wb = 1'b0;
    i_hit = 1'b1; d_hit = 1'b1; i_ready = 1'b0; d_ready = 1'b0;
    redirect = 1'b0; btb_upd = 1'b0;
  endtask

  // Ends 1 time unit after a rising edge with reset released.
  task automatic do_reset();
    idle_inputs();
    reset_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [12:0] got;
    idle_inputs();
    reset_n = 1'b0;
    i_hit = 1'b0; d_hit = 1'b0; redirect = 1'b1; btb_upd = 1'b1; id_halt = 1'b1;
    sb.push_back(exp_o(M_ADV, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0));
    @(negedge clk);
    got = sb.pop_front();
    n_cmp++;
    if (obs !== got) begin
      n_err++;
      $display("FAIL reset_outputs got=%b want=%b", obs, got);
    end
    n_cmp++;
    if (stall_cnt !== '0 || miss_cnt !== '0) begin
      n_err++;
      $display("FAIL reset_counters got=%0d/%0d want=0/0", stall_cnt, miss_cnt);
    end
    @(posedge clk);
    #1 reset_n = 1'b1;
    idle_inputs();
  endtask

  task automatic test_forwarding();
    logic [12:0] e, got;
    do_reset();
    for (int c = 0; c < 7; c++) begin
      idle_inputs();
      id_use_rs = 1'b1; id_use_rt = 1'b1;
      case (c)
        0: begin id_rs = 2; id_rt = 2; rw_ex = 1; dest_ex = 2; rw_m = 1; dest_m = 2;
                 e = exp_o(M_ADV, 0, 0, 0, 2'd1, 2'd1); end
        1: begin id_rs = 2; id_rt = 2; rw_m = 1; dest_m = 2; dest_ex = 2;
                 e = exp_o(M_ADV, 0, 0, 0, 2'd2, 2'd2); end
        2: begin id_rs = 2; id_rt = 2; rw_wb = 1; dest_wb = 2; dest_m = 2; dest_ex = 2;
                 e = exp_o(M_ADV, 0, 0, 0, 2'd3, 2'd3); end
        3: begin id_rs = 2; id_rt = 2; dest_ex = 2; dest_m = 2; dest_wb = 2;
                 e = exp_o(M_ADV, 0, 0, 0, 2'd0, 2'd0); end
        4: begin id_rs = 1; id_rt = 3; rw_ex = 1; dest_ex = 0; rw_m = 1; dest_m = 1;
                 rw_wb = 1; dest_wb = 3; e = exp_o(M_ADV, 0, 0, 0, 2'd2, 2'd3); end
        5: begin id_use_rs = 0; id_rs = 1; id_rt = 3; rw_m = 1; dest_m = 1;
                 rw_wb = 1; dest_wb = 3; e = exp_o(M_ADV, 0, 0, 0, 2'd0, 2'd3); end
        default: begin id_rs = 2; id_rt = 2; rw_m = 1; dest_m = 2; rw_wb = 1; dest_wb = 2;
                 e = exp_o(M_ADV, 0, 0, 0, 2'd2, 2'd2); end
      endcase
      sb.push_back(e);
      @(negedge clk);
      got = sb.pop_front();
      n_cmp++;
      if (obs !== got) begin
        n_err++;
        $display("FAIL fwd c%0d got=%b want=%b", c, obs, got);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_load_use();
    logic [12:0] got;
    do_reset();
    for (int c = 0; c < 3; c++) begin
      idle_inputs();
      if (c == 0) begin
        ex_is_load = 1; rw_ex = 1; dest_ex = 1; id_rs = 1; id_use_rs = 1;
        sb.push_back(exp_o(M_FE0, 0, 0, 0, 2'd1, 2'd0));
        sb1.push_back(exp_o(M_FE0, 0, 0, 0, 2'd1, 2'd0));
      end else if (c == 1) begin
        sb.push_back(exp_o(M_FE0, 0, 0, 0, 2'd0, 2'd0));
        sb1.push_back(exp_o(M_ADV, 0, 0, 0, 2'd0, 2'd0));
      end else begin
        sb.push_back(exp_o(M_ADV, 0, 0, 0, 2'd0, 2'd0));
        sb1.push_back(exp_o(M_ADV, 0, 0, 0, 2'd0, 2'd0));
      end
      @(negedge clk);
      got = sb.pop_front();
      n_cmp++;
      if (obs !== got) begin
        n_err++;
        $display("FAIL load_use_b2 c%0d got=%b want=%b", c, obs, got);
      end
      got = sb1.pop_front();
      n_cmp++;
      if (obs1 !== got) begin
        n_err++;
        $display("FAIL load_use_b1 c%0d got=%b want=%b", c, obs1, got);
      end
      @(posedge clk);
      #1;
    end
  endtask

  // I-miss with the fill 4 cycles later, plus redirect gating.
  task automatic test_i_miss();
    logic [12:0] e, got;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      idle_inputs();
      if (c <= 3) i_hit = 1'b0;
      case (c)
        2: begin redirect = 1; btb_upd = 1; e = exp_o(M_FE0, 0, 0, 0, 0, 0); end
        4: begin i_ready = 1; redirect = 1; btb_upd = 1; e = exp_o(M_ADV, 1, 1, 0, 0, 0); end
        5: begin redirect = 1; e = exp_o(M_ADV, 1, 0, 0, 0, 0); end
        default: e = exp_o(M_FE0, 0, 0, 0, 0, 0);
      endcase
      sb.push_back(e);
      @(negedge clk);
      got = sb.pop_front();
      n_cmp++;
      if (obs !== got) begin
        n_err++;
        $display("FAIL i_miss c%0d got=%b want=%b", c, obs, got);
      end
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if (stall_cnt !== CNT_W'(4 * PERF) || miss_cnt !== CNT_W'(PERF)) begin
      n_err++;
      $display("FAIL i_miss_counters got=%0d/%0d want=%0d/%0d", stall_cnt, miss_cnt, 4 * PERF, PERF);
    end
  endtask

  // D-miss then I-miss; d_ready at cycle 3, i_ready at cycle 6.
  task automatic test_both();
    logic [12:0] e, got;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      idle_inputs();
      if (c <= 6) d_hit = 1'b0;
      if (c >= 1 && c <= 6) i_hit = 1'b0;
      if (c == 3) d_ready = 1'b1;
      if (c == 6) i_ready = 1'b1;
      if (c == 0)      e = exp_o(M_ALL0, 0, 0, 0, 0, 0);
      else if (c < 6)  e = exp_o(M_ALL0, 0, 0, 1, 0, 0);
      else if (c == 6) e = exp_o(M_ADV, 0, 0, 1, 0, 0);
      else             e = exp_o(M_ADV, 0, 0, 0, 0, 0);
      sb.push_back(e);
      @(negedge clk);
      got = sb.pop_front();
      n_cmp++;
      if (obs !== got) begin
        n_err++;
        $display("FAIL both c%0d got=%b want=%b", c, obs, got);
      end
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if (stall_cnt !== CNT_W'(6 * PERF) || miss_cnt !== CNT_W'(2 * PERF)) begin
      n_err++;
      $display("FAIL both_counters got=%0d/%0d want=%0d/%0d", stall_cnt, miss_cnt, 6 * PERF, 2 * PERF);
    end
  endtask

  // Reset while in BOTH with d_done latched. The latched flag must be dropped.
  task automatic test_reset_mid_miss();
    logic [12:0] e, got;
    do_reset();
    for (int c = 0; c < 9; c++) begin
      idle_inputs();
      case (c)
        0: begin d_hit = 0; e = exp_o(M_ALL0, 0, 0, 0, 0, 0); end
        1: begin d_hit = 0; i_hit = 0; e = exp_o(M_ALL0, 0, 0, 1, 0, 0); end
        2: begin d_hit = 0; i_hit = 0; d_ready = 1; e = exp_o(M_ALL0, 0, 0, 1, 0, 0); end
        3: begin reset_n = 0; d_hit = 0; i_hit = 0; redirect = 1;
                 e = exp_o(M_ADV, 0, 0, 0, 0, 0); end
        4: begin reset_n = 1; d_hit = 0; e = exp_o(M_ALL0, 0, 0, 0, 0, 0); end
        5: begin d_hit = 0; i_hit = 0; e = exp_o(M_ALL0, 0, 0, 1, 0, 0); end
        6: begin d_hit = 0; i_hit = 0; i_ready = 1; e = exp_o(M_ALL0, 0, 0, 1, 0, 0); end
        7: begin d_ready = 1; e = exp_o(M_ADV, 0, 0, 1, 0, 0); end
        default: e = exp_o(M_ADV, 0, 0, 0, 0, 0);
      endcase
      sb.push_back(e);
      @(negedge clk);
      got = sb.pop_front();
      n_cmp++;
      if (obs !== got) begin
        n_err++;
        $display("FAIL reset_mid_miss c%0d got=%b want=%b", c, obs, got);
      end
      if (c == 3) begin
        n_cmp++;
        if (stall_cnt !== '0) begin
          n_err++;
          $display("FAIL reset_mid_miss_cnt got=%0d want=0", stall_cnt);
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_halt();
    logic [12:0] e, got;
    do_reset();
    for (int c = 0; c < 9; c++) begin
      idle_inputs();
      case (c)
        0: begin id_halt = 1; e = exp_o(M_FE0, 0, 0, 0, 0, 0); end
        1: begin id_halt = 1; redirect = 1; btb_upd = 1; e = exp_o(M_FE0, 0, 0, 0, 0, 0); end
        2: begin id_halt = 1; d_hit = 0; e = exp_o(M_ALL0, 0, 0, 0, 0, 0); end
        3: begin id_halt = 1; d_ready = 1; e = exp_o(M_ADV, 0, 0, 0, 0, 0); end
        4: e = exp_o(M_ADV, 0, 0, 0, 0, 0);
        5: begin id_halt = 1; ex_is_load = 1; rw_ex = 1; dest_ex = 1; id_rs = 1; id_use_rs = 1;
                 e = exp_o(M_FE0, 0, 0, 0, 2'd1, 0); end
        6: begin ex_is_load = 1; rw_ex = 1; dest_ex = 1; id_rs = 1; id_use_rs = 1;
                 e = exp_o(M_FE0, 0, 0, 0, 2'd1, 0); end
        7: e = exp_o(M_FE0, 0, 0, 0, 0, 0);
        default: e = exp_o(M_ADV, 0, 0, 0, 0, 0);
      endcase
      sb.push_back(e);
      @(negedge clk);
      got = sb.pop_front();
      n_cmp++;
      if (obs !== got) begin
        n_err++;
        $display("FAIL halt c%0d got=%b want=%b", c, obs, got);
      end
      @(posedge clk);
      #1;
    end
  endtask

  // Ready pulses that no state expects, and fills completing in back-to-back
  // and same-cycle combinations.
  task automatic test_back_to_back();
    logic [12:0] e, got;
    do_reset();
    for (int c = 0; c < 14; c++) begin
      idle_inputs();
      case (c)
        0:  begin i_ready = 1; d_ready = 1; e = exp_o(M_ADV, 0, 0, 0, 0, 0); end
        1:  begin i_hit = 0; e = exp_o(M_FE0, 0, 0, 0, 0, 0); end
        2:  begin i_hit = 0; e = exp_o(M_FE0, 0, 0, 0, 0, 0); end
        3:  begin i_ready = 1; e = exp_o(M_ADV, 0, 0, 0, 0, 0); end
        4:  begin d_hit = 0; e = exp_o(M_ALL0, 0, 0, 0, 0, 0); end
        5:  begin d_hit = 0; i_ready = 1; e = exp_o(M_ALL0, 0, 0, 0, 0, 0); end
        6:  begin d_hit = 0; d_ready = 1; e = exp_o(M_ADV, 0, 0, 0, 0, 0); end
        7:  begin d_hit = 0; e = exp_o(M_ALL0, 0, 0, 0, 0, 0); end
        8:  begin i_hit = 0; d_ready = 1; e = exp_o(M_ALL0, 0, 0, 1, 0, 0); end
        9:  begin i_ready = 1; e = exp_o(M_ADV, 0, 0, 1, 0, 0); end
        10: begin i_hit = 0; e = exp_o(M_FE0, 0, 0, 0, 0, 0); end
        11: begin d_hit = 0; i_ready = 1; e = exp_o(M_ALL0, 0, 0, 1, 0, 0); end
        12: begin d_ready = 1; e = exp_o(M_ADV, 0, 0, 1, 0, 0); end
        default: e = exp_o(M_ADV, 0, 0, 0, 0, 0);
      endcase
      sb.push_back(e);
      @(negedge clk);
      got = sb.pop_front();
      n_cmp++;
      if (obs !== got) begin
        n_err++;
        $display("FAIL back_to_back c%0d got=%b want=%b", c, obs, got);
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    idle_inputs();
    reset_n = 1'b0;
    #2;
    test_reset();
    test_forwarding();
    test_load_use();
    test_i_miss();
    test_both();
    test_reset_mid_miss();
    test_halt();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout compared=%0d", n_cmp);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pipe_hazard_arbiter.md
Name: pipe_hazard_arbiter

Overview:
- Parametrised pipeline hazard and stall arbiter for the 5-stage core with split I/D caches.
- Resolves data forwarding across the EX, MEM and WB stages.
- Inserts a configurable number of load-use bubbles.
- Sequences I-miss, D-miss and overlapping miss stalls. Ready pulses are latched, so ready ordering does not matter.
- Gates mispredict flush and BTB update on pipeline advance. Sits between control_unit, datapath and both caches.

Parameters:
REG_AW, 2, register address width
LU_BUBBLES, 1, bubbles inserted on load-use hazard (1..3)
CNT_W, 16, performance counter width

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
id_rs, id_rt  in  REG_AW each  source register addresses of the instruction in ID
id_use_rs, id_use_rt  in  1 each  ID instruction reads rs / rt
id_halt  in  1  HLT in ID
ex_is_load  in  1  load in EX
dest_ex, dest_m, dest_wb  in  REG_AW each  destination register per stage
rw_ex, rw_m, rw_wb  in  1 each  RegWrite per stage
i_hit, d_hit  in  1 each  cache hit (d_hit is 1 when there is no D access)
i_ready, d_ready  in  1 each  single-cycle fill-complete pulses
redirect  in  1  branch/jump mispredict detected in ID
btb_upd  in  1  ID instruction requests BTB write
pc_we, id_we, ex_we, m_we, wb_we  out  1 each  stage latch enables
bubble_ex  out  1  inject NOP into ID/EX
flush_id  out  1  squash IF/ID
btb_we  out  1  gated BTB write
fwd_a, fwd_b  out  2 each  forward select: 0 RF, 1 EX, 2 MEM, 3 WB
both_access  out  1  both caches missing concurrently
stall_cnt, miss_cnt  out  CNT_W each  performance counters

Behaviour:
- Reset is asynchronous and active-low on reset_n; the clock is clk. While reset_n is low:
  - state=IDLE, all *_we=1, bubble_ex=0, flush_id=0, btb_we=0, both_access=0;
  - bubble counter=0, ready flags cleared, counters=0.
- Forwarding is purely combinational.
  - fwd_a=1 if id_use_rs & rw_ex & id_rs==dest_ex; else 2 on the MEM match; else 3 on the WB match; else 0.
  - Priority is EX>MEM>WB. fwd_b is identical using id_rt / id_use_rt.
- Load-use hazard: lu = ex_is_load & ((id_use_rs & rw_ex & id_rs==dest_ex) | (id_use_rt & rw_ex & id_rt==dest_ex)).
- Enable shorthands: ALL0 means every *_we=0. FE0 means pc_we=id_we=0, ex/m/wb_we=1, bubble_ex=1. ADV means every *_we=1.
- FSM states: IDLE, I_MISS, D_MISS, BOTH, LU_STALL.
- IDLE, checked in priority order:
  - !d_hit -> D_MISS, ALL0 this cycle.
  - else !i_hit -> I_MISS, FE0.
  - else lu -> LU_STALL, FE0, bubble counter loaded with LU_BUBBLES-1.
  - else ADV.
- I_MISS:
  - !d_hit -> BOTH with ALL0; i_ready is latched if present the same cycle.
  - else i_ready -> IDLE with ADV.
  - else FE0.
- D_MISS:
  - !i_hit -> BOTH with ALL0; d_ready is latched if present.
  - else d_ready -> IDLE with ADV.
  - else ALL0.
- BOTH:
  - ALL0 and both_access=1.
  - Sticky flags i_done/d_done are set on their ready pulses.
  - When both are done (including a pulse arriving this cycle): ADV, flags cleared, -> IDLE.
- LU_STALL:
  - !d_hit -> D_MISS with ALL0.
  - else if counter==0 -> IDLE with ADV.
  - else decrement the counter, FE0.
- HLT override: id_halt with the state in IDLE or LU_STALL and no miss forces pc_we=id_we=0 and bubble_ex=1; later stages drain; the state is unchanged. A miss takes precedence over HLT.
- Redirect gating: flush_id=redirect & pc_we; btb_we=btb_upd & pc_we. Both are 0 whenever the front end is stalled, so a redirect is acted on only in its advance cycle.
- A reset mid-miss returns to IDLE immediately and discards latched ready flags.
- Ready pulses that arrive in a state not expecting them are ignored.

Optional Feature:
- Macro: PERF_CNT_EN.
- Defined:
  - stall_cnt increments each cycle pc_we==0;
  - miss_cnt increments on each IDLE->I_MISS / IDLE->D_MISS / I_MISS->BOTH / D_MISS->BOTH transition;
  - both counters saturate at all-ones.
- Undefined: both outputs are constant 0 and no counter flops are built.

Test Plan:
- EX writes r2, ID reads rs=2 and rt=2, MEM also writes r2 -> fwd_a=1, fwd_b=1. Remove the EX write -> fwd_a=2. No write in any stage -> fwd_a=0.
- LU_BUBBLES=2, load r1 in EX, ID uses rs=1 -> 2 cycles FE0 with bubble_ex=1, then ADV. With LU_BUBBLES=1 -> 1 stall cycle.
- i_hit=0 in IDLE, i_ready pulses 4 cycles later -> FE0 for 4 cycles, ADV on the pulse cycle. With PERF_CNT_EN, miss_cnt=1 and stall_cnt=4.
- D-miss then I-miss next cycle, d_ready at cycle 3 and i_ready at cycle 6 -> both_access=1 for cycles 1-6, ALL0 throughout, ADV at cycle 6, then IDLE.
- redirect=1 during I_MISS -> flush_id=0. redirect=1 on the completion cycle -> flush_id=1 and btb_we=btb_upd.
- Assert reset_n low during BOTH with d_done latched -> all outputs at reset values. After release, i_ready alone does not advance the pipeline.
